serial_pattern_tx: RTL and testbench

- Parallel-in/serial-out pattern transmitter. Generates the single-bit serial stream X consumed by the team's clocked sequence detectors.
- Accepts a pattern word over a valid/ready handshake and shifts it out MSB-first, one bit per CLK.
- Supports a programmable bit length and a repeat count, so a detector bench or stimulus path can drive arbitrary bit sequences without hand-timed delays.

---
 rtl/sptx_pkg.sv | 29 ++
 rtl/piso_shreg.sv | 28 ++
 rtl/serial_pattern_tx.sv | 133 +++++++++++++
 tb/tb_serial_pattern_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sptx_pkg.sv
// Shared types and helpers for the serial pattern transmitter and its shift register.
package sptx_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Map a requested length onto 1..WIDTH; 0 or oversize means a full word.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    if (len == '0 || len > LEN_W'(WIDTH)) return LEN_W'(WIDTH);
    return len;
  endfunction

  // Select v[idx] without a width-mismatched index expression.
  function automatic logic bit_at(input logic [WIDTH-1:0] v, input logic [LEN_W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (idx == LEN_W'(i)) b = v[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, left-shifting register whose head bit sits at position len-1.
module piso_shreg
  import sptx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  input  logic [LEN_W-1:0] len,
  output logic             msb_c
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign msb_c = bit_at(sr, len - LEN_W'(1));

endmodule

// File: rtl/serial_pattern_tx.sv
// Parallel-in/serial-out pattern transmitter: MSB-first, programmable length and repeat count.
module serial_pattern_tx
  import sptx_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] LOAD_DATA,
  input  logic [LEN_W-1:0] LOAD_LEN,
  input  logic [CNT_W-1:0] REPEAT,
  input  logic             ABORT,
  output logic             X,
  output logic             X_VALID,
  output logic             BUSY,
  output logic             DONE
);

  state_t           state_q, state_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             sr_load, sr_shift;
  logic [WIDTH-1:0] sr_din;
  logic             sr_msb_c;
  logic [LEN_W-1:0] load_len_c;

  assign LOAD_READY = (state_q == ST_IDLE) & ~ABORT;
  assign load_len_c = eff_len(LOAD_LEN);

  // The shift register holds the bits still to come, so X itself can be a flop.
  piso_shreg u_shreg (
    .clk   (CLK),
    .rst_n (RST_N),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .len   (len_q),
    .msb_c (sr_msb_c)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = 1'b0;
    xv_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    rep_d     = rep_q;
    shadow_d  = shadow_q;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_din    = '0;

    case (state_q)
      ST_IDLE: begin
        if (LOAD_VALID && LOAD_READY) begin
          state_d   = ST_SHIFT;
          shadow_d  = LOAD_DATA;
          len_d     = load_len_c;
          bit_cnt_d = load_len_c - LEN_W'(1);
          rep_d     = REPEAT;
          x_d       = bit_at(LOAD_DATA, load_len_c - LEN_W'(1));
          xv_d      = 1'b1;
          busy_d    = 1'b1;
          sr_load   = 1'b1;
          sr_din    = LOAD_DATA << 1;
        end
      end
      ST_SHIFT: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (bit_cnt_q == '0) begin
          if (rep_q != '0) begin
            rep_d     = rep_q - CNT_W'(1);
            bit_cnt_d = len_q - LEN_W'(1);
            x_d       = bit_at(shadow_q, len_q - LEN_W'(1));
            xv_d      = 1'b1;
            busy_d    = 1'b1;
            sr_load   = 1'b1;
            sr_din    = shadow_q << 1;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - LEN_W'(1);
          x_d       = sr_msb_c;
          xv_d      = 1'b1;
          busy_d    = 1'b1;
          sr_shift  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      x_q       <= 1'b0;
      xv_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      rep_q     <= '0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      xv_q      <= xv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      rep_q     <= rep_d;
      shadow_q  <= shadow_d;
    end
  end

  assign X       = x_q;
  assign X_VALID = xv_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed and randomized checks of serial_pattern_tx against a bit-list reference model.
module tb_serial_pattern_tx;

  logic       CLK;
  logic       RST_N;
  logic       LOAD_VALID;
  logic       LOAD_READY;
  logic [7:0] LOAD_DATA;
  logic [3:0] LOAD_LEN;
  logic [3:0] REPEAT;
  logic       ABORT;
  logic       X;
  logic       X_VALID;
  logic       BUSY;
  logic       DONE;

  int n_assert = 0;
  int n_fail   = 0;

  serial_pattern_tx dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .LOAD_VALID (LOAD_VALID),
    .LOAD_READY (LOAD_READY),
    .LOAD_DATA  (LOAD_DATA),
    .LOAD_LEN   (LOAD_LEN),
    .REPEAT     (REPEAT),
    .ABORT      (ABORT),
    .X          (X),
    .X_VALID    (X_VALID),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Offer a word; returns at the first cycle after the accepting edge.
  task automatic start_word(input logic [7:0] d, input logic [3:0] len, input logic [3:0] rep);
    @(negedge CLK);
    LOAD_VALID = 1'b1;
    LOAD_DATA  = d;
    LOAD_LEN   = len;
    REPEAT     = rep;
    #1 chk("ready_before_accept", LOAD_READY, 1'b1);
    @(negedge CLK);
    LOAD_VALID = 1'b0;
  endtask

  // Expected stream: every pass sends the field MSB first, passes back to back.
  task automatic check_stream(input logic [7:0] d, input logic [3:0] len, input logic [3:0] rep);
    int   l;
    logic q[$];
    l = (len == 4'd0 || len > 4'd8) ? 8 : int'(len);
    for (int p = 0; p <= int'(rep); p++)
      for (int i = l - 1; i >= 0; i--) q.push_back(d[i]);
    for (int k = 0; k < q.size(); k++) begin
      if (k != 0) @(negedge CLK);
      chk("x_bit", X, q[k]);
      chk("x_valid_bit", X_VALID, 1'b1);
      chk("busy_bit", BUSY, 1'b1);
      chk("done_early", DONE, 1'b0);
    end
    @(negedge CLK);
    chk("done_pulse", DONE, 1'b1);
    chk("x_after", X, 1'b0);
    chk("x_valid_after", X_VALID, 1'b0);
    chk("busy_after", BUSY, 1'b0);
    chk("ready_in_done", LOAD_READY, 1'b1);
  endtask

  initial begin
    RST_N      = 1'b0;
    LOAD_VALID = 1'b0;
    LOAD_DATA  = 8'h00;
    LOAD_LEN   = 4'd0;
    REPEAT     = 4'd0;
    ABORT      = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_x", X, 1'b0);
    chk("rst_xv", X_VALID, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_ready", LOAD_READY, 1'b1);
    RST_N = 1'b1;

    // Single full-width pass
    start_word(8'hB4, 4'd8, 4'd0);
    check_stream(8'hB4, 4'd8, 4'd0);
    @(negedge CLK);
    chk("done_one_cycle", DONE, 1'b0);

    // Short length with one repeat, no gap between passes
    start_word(8'h06, 4'd4, 4'd1);
    check_stream(8'h06, 4'd4, 4'd1);

    // Length 0 clamps to full width
    start_word(8'h81, 4'd0, 4'd0);
    check_stream(8'h81, 4'd0, 4'd0);

    // Oversize length clamps to full width; bits above field ignored for short lengths
    start_word(8'h3C, 4'd13, 4'd0);
    check_stream(8'h3C, 4'd13, 4'd0);
    start_word(8'hF5, 4'd3, 4'd0);
    check_stream(8'hF5, 4'd3, 4'd0);

    // Single-bit word repeated to the counter maximum
    start_word(8'h01, 4'd1, 4'd15);
    check_stream(8'h01, 4'd1, 4'd15);

    // Single-bit pulse
    start_word(8'h01, 4'd1, 4'd0);
    check_stream(8'h01, 4'd1, 4'd0);

    // Abort during the third bit
    start_word(8'hFF, 4'd8, 4'd0);
    chk("abort_b1", X_VALID, 1'b1);
    @(negedge CLK);
    chk("abort_b2", X_VALID, 1'b1);
    @(negedge CLK);
    chk("abort_b3", X_VALID, 1'b1);
    ABORT = 1'b1;
    #1 chk("abort_ready_low", LOAD_READY, 1'b0);
    @(negedge CLK);
    ABORT = 1'b0;
    chk("abort_xv", X_VALID, 1'b0);
    chk("abort_x", X, 1'b0);
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_no_done", DONE, 1'b0);
    @(negedge CLK);
    chk("abort_no_done2", DONE, 1'b0);
    chk("abort_xv2", X_VALID, 1'b0);

    // Abort in idle blocks acceptance
    ABORT      = 1'b1;
    LOAD_VALID = 1'b1;
    LOAD_DATA  = 8'hAA;
    LOAD_LEN   = 4'd8;
    REPEAT     = 4'd0;
    #1 chk("idle_abort_ready", LOAD_READY, 1'b0);
    @(negedge CLK);
    ABORT      = 1'b0;
    LOAD_VALID = 1'b0;
    chk("idle_abort_busy", BUSY, 1'b0);
    chk("idle_abort_xv", X_VALID, 1'b0);
    @(negedge CLK);
    chk("idle_abort_busy2", BUSY, 1'b0);

    // Back-to-back with LOAD_VALID held high
    LOAD_VALID = 1'b1;
    LOAD_DATA  = 8'hC3;
    LOAD_LEN   = 4'd8;
    REPEAT     = 4'd0;
    @(negedge CLK);
    LOAD_DATA  = 8'h5A;
    LOAD_LEN   = 4'd4;
    REPEAT     = 4'd1;
    check_stream(8'hC3, 4'd8, 4'd0);
    @(negedge CLK);
    LOAD_VALID = 1'b0;
    check_stream(8'h5A, 4'd4, 4'd1);

    // Asynchronous reset mid-transmission, then a normal word
    start_word(8'hB4, 4'd8, 4'd2);
    repeat (2) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_x", X, 1'b0);
    chk("mid_rst_xv", X_VALID, 1'b0);
    chk("mid_rst_busy", BUSY, 1'b0);
    chk("mid_rst_done", DONE, 1'b0);
    chk("mid_rst_ready", LOAD_READY, 1'b1);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_done", DONE, 1'b0);
    start_word(8'h9E, 4'd7, 4'd1);
    check_stream(8'h9E, 4'd7, 4'd1);

    // Randomized words
    for (int n = 0; n < 24; n++) begin
      logic [7:0] rd;
      logic [3:0] rl;
      logic [3:0] rr;
      rd = 8'($urandom);
      rl = 4'($urandom_range(0, 15));
      rr = 4'($urandom_range(0, 3));
      start_word(rd, rl, rr);
      check_stream(rd, rl, rr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
